// File: rtl/dm_cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the
// direct-mapped cache request sequencer.
package dm_cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int INDEX_W        = 8;
  localparam int OFFSET_W       = 6;
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W     = OFFSET_W - 2;
  localparam int WORDS_PER_LINE = 1 << WORD_SEL_W;
  localparam int RAM_AW         = INDEX_W + WORD_SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_DATA = 3'd3,
    ST_READ      = 3'd4,
    ST_RESPOND   = 3'd5
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[2 +: WORD_SEL_W];
  endfunction

  function automatic logic [1:0] addr_byte(input logic [ADDR_W-1:0] a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/dm_cache_data_ram.sv
// Single-port line data store: one write or one read per cycle, read data
// registered so it appears the cycle after the address is presented.
module dm_cache_data_ram
  import dm_cache_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<RAM_AW)-1];
  logic [31:0] rdata_q;

  // Write on enable, otherwise capture the addressed word for next cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Request sequencer for a 256-line x 64 B direct-mapped byte-read cache:
// tag lookup, 16-beat line refill on miss, byte response and hit/miss stats.
module dm_cache_ctrl #(
  parameter int ADDR_W   = dm_cache_pkg::ADDR_W,
  parameter int INDEX_W  = dm_cache_pkg::INDEX_W,
  parameter int OFFSET_W = dm_cache_pkg::OFFSET_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [7:0]        resp_data,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  import dm_cache_pkg::*;

  localparam int LINES = 1 << INDEX_W;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  hit_q;
  logic [WORD_SEL_W-1:0] beat_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem_q [0:LINES-1];
  logic [CNT_W-1:0]      hit_count_q, miss_count_q;

  logic [INDEX_W-1:0]    idx_s;
  logic [TAG_W-1:0]      tag_s;
  logic                  lookup_hit_s;
  logic                  fill_last_s;
  logic                  accept_s;
  logic                  ram_we_s;
  logic [RAM_AW-1:0]     ram_addr_s;
  logic [31:0]           ram_rdata_s;

  assign idx_s        = addr_index(addr_q);
  assign tag_s        = addr_tag(addr_q);
  assign lookup_hit_s = valid_q[idx_s] && (tag_mem_q[idx_s] == tag_s);
  assign fill_last_s  = (state_q == ST_FILL_DATA) && mem_resp_valid &&
                        (beat_q == WORD_SEL_W'(WORDS_PER_LINE - 1));
  assign accept_s     = (state_q == ST_IDLE) && req_valid && !flush;

  dm_cache_data_ram u_data_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (mem_resp_data),
    .rdata_o (ram_rdata_s)
  );

  // Next-state decode plus handshake and RAM port control.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    ram_we_s      = 1'b0;
    ram_addr_s    = {idx_s, addr_word(addr_q)};
    case (state_q)
      ST_IDLE: begin
        req_ready = !flush && !reset;
        if (accept_s) state_d = ST_LOOKUP;
        else          state_d = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (lookup_hit_s) state_d = ST_RESPOND;
        else              state_d = ST_FILL_REQ;
      end
      ST_FILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_FILL_DATA;
        else               state_d = ST_FILL_REQ;
      end
      ST_FILL_DATA: begin
        ram_addr_s = {idx_s, beat_q};
        ram_we_s   = mem_resp_valid;
        if (fill_last_s) state_d = ST_READ;
        else             state_d = ST_FILL_DATA;
      end
      ST_READ:    state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control state, request latch, valid bits, beat counter and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      hit_q        <= 1'b0;
      beat_q       <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && flush) valid_q <= '0;
      if (accept_s) addr_q <= req_addr;
      if (state_q == ST_LOOKUP) begin
        hit_q <= lookup_hit_s;
        if (lookup_hit_s) hit_count_q  <= hit_count_q + CNT_W'(1);
        else              miss_count_q <= miss_count_q + CNT_W'(1);
      end
      if (state_q == ST_FILL_REQ) beat_q <= '0;
      else if (state_q == ST_FILL_DATA && mem_resp_valid) beat_q <= beat_q + WORD_SEL_W'(1);
      if (fill_last_s) valid_q[idx_s] <= 1'b1;
    end
  end

  // Tag store is written once the last beat of a refill lands; not reset.
  always_ff @(posedge clk) begin
    if (fill_last_s && !reset) tag_mem_q[idx_s] <= tag_s;
  end

  // Response byte steering (little-endian) and output gating.
  always_comb begin
    resp_data = 8'h00;
    if (resp_valid) begin
      case (addr_byte(addr_q))
        2'd0:    resp_data = ram_rdata_s[7:0];
        2'd1:    resp_data = ram_rdata_s[15:8];
        2'd2:    resp_data = ram_rdata_s[23:16];
        2'd3:    resp_data = ram_rdata_s[31:24];
        default: resp_data = 8'h00;
      endcase
    end else begin
      resp_data = 8'h00;
    end
  end

  assign resp_valid   = (state_q == ST_RESPOND);
  assign resp_hit     = resp_valid && hit_q;
  assign mem_req_addr = mem_req_valid ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}}
                                      : {ADDR_W{1'b0}};
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule
